// File: rtl/dac_level_sched.sv
// dac_level_sched -- per-shot level scheduler for the 4-channel threshold/gain DAC.
//
// Each rising edge of the shot sync starts a walk through a host-written profile table.
// For every step, four 8-bit levels go to the SPI DAC serializer with a 1-clk load
// pulse. The scheduler then waits for the serializer to go idle and holds the levels
// for the programmed number of ticks before it moves to the next step.
//
// Ports
//   clk, rst_n        system clock, async active-low reset
//   i_sync            shot sync (level); a rising edge starts or restarts a sequence
//   i_num_steps       steps per shot, 0 disables, values above 2**ADDR_W are clamped
//   i_wr_en/addr/data table write port, data = {lvl3,lvl2,lvl1,lvl0,hold}
//   i_dac_busy        serializer busy
//   o_dac_data_0..3   registered levels, o_dac_load = 1-clk load strobe
//   o_step            step currently applied, o_active = sequence in progress
//   o_done            1-clk pulse at the last step's hold expiry
//   o_overrun         sticky, set when a sync edge arrives mid-sequence

module dac_level_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
endmodule

module dac_level_sched #(
  parameter int ADDR_W = 4,
  parameter int HOLD_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_sync,
  input  logic [ADDR_W:0]      i_num_steps,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [31+HOLD_W:0]   i_wr_data,
  input  logic                 i_dac_busy,
  output logic [7:0]           o_dac_data_0,
  output logic [7:0]           o_dac_data_1,
  output logic [7:0]           o_dac_data_2,
  output logic [7:0]           o_dac_data_3,
  output logic                 o_dac_load,
  output logic [ADDR_W-1:0]    o_step,
  output logic                 o_active,
  output logic                 o_done,
  output logic                 o_overrun
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0]   MAXN  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_S = (ADDR_W+1)'(1);
  localparam logic [HOLD_W-1:0] ONE_H = HOLD_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_t;
  typedef struct packed {
    logic [3:0][7:0]   lvl;
    logic [HOLD_W-1:0] hold;
  } entry_t;

  entry_t tbl [DEPTH];
  entry_t rd;

  state_t            state, state_n;
  logic [ADDR_W-1:0] step, step_n;
  logic [HOLD_W-1:0] hold_cnt;
  logic              prev_sync, edge_r, guard, rpend, rpend_n, overrun, done;
  logic [ADDR_W:0]   eff_num, step_p1;
  logic              last, abort, in_flight;
  logic [3:0][7:0]   lvl_q;

  always_ff @(posedge clk)
    if (i_wr_en) tbl[i_wr_addr] <= entry_t'(i_wr_data);

  // Levels and hold are fetched as a step is entered, so the index is the next step.
  assign rd      = tbl[step_n];
  assign eff_num = (i_num_steps > MAXN) ? MAXN : i_num_steps;
  assign step_p1 = {1'b0, step} + ONE_S;
  // Live compare: shrinking i_num_steps below the current step also ends the shot.
  assign last      = (step_p1 >= eff_num);
  assign abort     = edge_r && (state != IDLE);
  // LOAD and WAIT mean the serializer may still be (or is about to be) shifting.
  assign in_flight = (state == LOAD) || (state == WAIT) || i_dac_busy;

  always_comb begin
    state_n = state;
    step_n  = step;
    rpend_n = rpend;
    done    = 1'b0;
    case (state)
      IDLE: if (edge_r && (i_num_steps != '0)) begin
        state_n = LOAD;
        step_n  = '0;
      end
      LOAD: state_n = WAIT;
      WAIT: if (!guard && !i_dac_busy) begin
        if (rpend) begin
          state_n = LOAD;
          step_n  = '0;
          rpend_n = 1'b0;
        end else begin
          state_n = HOLD;
        end
      end
      HOLD: if (hold_cnt <= ONE_H) begin
        if (last) begin
          done    = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = LOAD;
          step_n  = step_p1[ADDR_W-1:0];
        end
      end
      default: state_n = IDLE;
    endcase
    // A restart waits in WAIT (guard included) until the transfer in flight drains.
    if (abort) begin
      done   = 1'b0;
      step_n = '0;
      if (in_flight) begin
        state_n = WAIT;
        rpend_n = 1'b1;
      end else begin
        state_n = LOAD;
        rpend_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      step      <= '0;
      hold_cnt  <= '0;
      prev_sync <= 1'b0;
      edge_r    <= 1'b0;
      guard     <= 1'b0;
      rpend     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      rpend     <= rpend_n;
      prev_sync <= i_sync;
      edge_r    <= i_sync & ~prev_sync;
      // Busy is first looked at two clocks after the load strobe.
      guard     <= (state == LOAD);
      if (abort) overrun <= 1'b1;
      if (state_n == LOAD)                        hold_cnt <= rd.hold;
      else if (state == HOLD && hold_cnt != '0)   hold_cnt <= hold_cnt - ONE_H;
    end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    dac_level_lane u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .ld   (state_n == LOAD),
      .d    (rd.lvl[g]),
      .q    (lvl_q[g])
    );
  end

  assign o_dac_data_0 = lvl_q[0];
  assign o_dac_data_1 = lvl_q[1];
  assign o_dac_data_2 = lvl_q[2];
  assign o_dac_data_3 = lvl_q[3];
  assign o_dac_load   = (state == LOAD);
  assign o_step       = step;
  assign o_active     = (state != IDLE);
  assign o_done       = done;
  assign o_overrun    = overrun;
endmodule

// File: tb/tb_dac_level_sched.sv
// Directed bench for dac_level_sched: a busy responder that holds busy for busy_len
// clocks after each load, a negedge monitor that logs loads/done/active, and a linear
// sequence of directed steps with hand-computed cycle positions.
module tb_dac_level_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_sync = 1'b0;
  logic [4:0]  i_num_steps = '0;
  logic        i_wr_en = 1'b0;
  logic [3:0]  i_wr_addr = '0;
  logic [47:0] i_wr_data = '0;
  logic        i_dac_busy = 1'b0;
  logic [7:0]  d0, d1, d2, d3;
  logic        o_dac_load, o_active, o_done, o_overrun;
  logic [3:0]  o_step;

  dac_level_sched #(.ADDR_W(4), .HOLD_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_sync(i_sync), .i_num_steps(i_num_steps),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_dac_busy(i_dac_busy),
    .o_dac_data_0(d0), .o_dac_data_1(d1), .o_dac_data_2(d2), .o_dac_data_3(d3),
    .o_dac_load(o_dac_load), .o_step(o_step), .o_active(o_active),
    .o_done(o_done), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int busy_len = 0;
  int bcnt = 0;
  always @(negedge clk) begin
    if (!rst_n)          bcnt = 0;
    else if (o_dac_load) bcnt = busy_len;
    else if (bcnt != 0)  bcnt = bcnt - 1;
    i_dac_busy = (bcnt != 0);
  end

  int          nld = 0, ndone = 0, nact = 0, done_cyc = -1;
  int          ld_cyc [64];
  int          ld_step[64];
  logic [31:0] ld_dat [64];
  always @(negedge clk) if (rst_n) begin
    if (o_dac_load && nld < 64) begin
      ld_cyc[nld]  = cyc;
      ld_step[nld] = int'(o_step);
      ld_dat[nld]  = {d3, d2, d1, d0};
      nld = nld + 1;
    end
    if (o_done) begin ndone = ndone + 1; done_cyc = cyc; end
    if (o_active) nact = nact + 1;
  end

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [47:0] ent(input logic [7:0] a, b, c, d, input logic [15:0] h);
    return {a, b, c, d, h};
  endfunction

  task automatic wr(input logic [3:0] a, input logic [47:0] dat);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = dat;
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic sync_pulse(output int c);
    c = cyc;
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
  endtask

  int c0, c1, bl, bd, ba;

  initial begin
    // reset state
    #3;
    chk("rst_active", o_active, 0);
    chk("rst_load", o_dac_load, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ovr", o_overrun, 0);
    chk("rst_step", o_step, 0);
    chk("rst_data", {d3, d2, d1, d0}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // T2 basic two-step shot, busy 4 clks per load
    wr(4'd0, ent(8'h10, 8'h20, 8'h30, 8'h40, 16'd5));
    wr(4'd1, ent(8'h50, 8'h60, 8'h70, 8'h80, 16'd3));
    i_num_steps = 5'd2; busy_len = 4;
    bl = nld; bd = ndone;
    sync_pulse(c0);
    repeat (28) tick();
    chk("t2_nld", nld - bl, 2);
    chk("t2_lat", ld_cyc[bl] - c0, 2);
    chk("t2_dat0", ld_dat[bl], 32'h10203040);
    chk("t2_step0", ld_step[bl], 0);
    chk("t2_cyc1", ld_cyc[bl+1] - c0, 12);
    chk("t2_dat1", ld_dat[bl+1], 32'h50607080);
    chk("t2_step1", ld_step[bl+1], 1);
    chk("t2_ndone", ndone - bd, 1);
    chk("t2_donecyc", done_cyc - c0, 19);
    chk("t2_idle", o_active, 0);
    chk("t2_keep", {d3, d2, d1, d0}, 32'h50607080);
    chk("t2_ovr", o_overrun, 0);

    // T3 disabled scheduler
    i_num_steps = 5'd0;
    bl = nld; ba = nact;
    sync_pulse(c0);
    repeat (10) tick();
    chk("t3_nld", nld - bl, 0);
    chk("t3_act", nact - ba, 0);

    // T1 async reset mid-HOLD
    i_num_steps = 5'd2;
    bd = ndone;
    sync_pulse(c0);
    repeat (7) tick();
    chk("t1_pre_act", o_active, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_act", o_active, 0);
    chk("t1_load", o_dac_load, 0);
    chk("t1_done", o_done, 0);
    chk("t1_step", o_step, 0);
    chk("t1_data", {d3, d2, d1, d0}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (25) tick();
    chk("t1_nodone", ndone - bd, 0);
    chk("t1_idle", o_active, 0);

    // T4 overrun during step 1
    chk("t4_ovr_pre", o_overrun, 0);
    wr(4'd0, ent(8'hA0, 8'hA0, 8'hA0, 8'hA0, 16'd2));
    wr(4'd1, ent(8'hA1, 8'hA1, 8'hA1, 8'hA1, 16'd2));
    wr(4'd2, ent(8'hA2, 8'hA2, 8'hA2, 8'hA2, 16'd2));
    i_num_steps = 5'd3; busy_len = 3;
    bl = nld; bd = ndone;
    sync_pulse(c0);
    repeat (10) tick();
    sync_pulse(c1);
    repeat (25) tick();
    chk("t4_ovr", o_overrun, 1);
    chk("t4_nld", nld - bl, 5);
    chk("t4_cyc2", ld_cyc[bl+2] - c0, 13);
    chk("t4_dat2", ld_dat[bl+2], 32'hA0A0A0A0);
    chk("t4_step2", ld_step[bl+2], 0);
    chk("t4_dat4", ld_dat[bl+4], 32'hA2A2A2A2);
    chk("t4_ndone", ndone - bd, 1);
    chk("t4_donecyc", done_cyc - c0, 30);
    repeat (5) tick();
    chk("t4_sticky", o_overrun, 1);

    // T5 zero hold with a 20-clk busy stall, then minimum period
    wr(4'd0, ent(8'h01, 8'h02, 8'h03, 8'h04, 16'd0));
    wr(4'd1, ent(8'h05, 8'h06, 8'h07, 8'h08, 16'd0));
    wr(4'd2, ent(8'h09, 8'h0A, 8'h0B, 8'h0C, 16'd0));
    i_num_steps = 5'd2; busy_len = 20;
    bl = nld; bd = ndone;
    sync_pulse(c0);
    repeat (50) tick();
    chk("t5_nld", nld - bl, 2);
    chk("t5_stall", ld_cyc[bl+1] - ld_cyc[bl], 22);
    chk("t5_donecyc", done_cyc - c0, 45);
    chk("t5_ndone", ndone - bd, 1);
    i_num_steps = 5'd3; busy_len = 0;
    bl = nld;
    sync_pulse(c0);
    repeat (20) tick();
    chk("t5_min1", ld_cyc[bl+1] - ld_cyc[bl], 4);
    chk("t5_min2", ld_cyc[bl+2] - ld_cyc[bl+1], 4);
    chk("t5_mindone", done_cyc - c0, 13);

    // T6 clamp to 16 steps, late write to entry 15
    for (int i = 0; i < 16; i++) wr(4'(i), ent(8'(i), 8'(i), 8'(i), 8'(i), 16'd1));
    i_num_steps = 5'd20; busy_len = 0;
    bl = nld; bd = ndone;
    sync_pulse(c0);
    repeat (58) tick();
    wr(4'd15, ent(8'hF5, 8'hF5, 8'hF5, 8'hF5, 16'd1));
    repeat (20) tick();
    chk("t6_nld", nld - bl, 16);
    chk("t6_ndone", ndone - bd, 1);
    for (int i = 0; i < 16; i++) chk("t6_step", ld_step[bl+i], i);
    chk("t6_dat14", ld_dat[bl+14], 32'h0E0E0E0E);
    chk("t6_dat15", ld_dat[bl+15], 32'hF5F5F5F5);
    chk("t6_cyc15", ld_cyc[bl+15] - c0, 62);
    chk("t6_laststep", o_step, 15);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
